// File: rtl/uart_char_rx_if.sv
// UART character receiver bus: serial line in, character/enter/status out.
// Ports: rx (serial pin), char_out, enter, frame_err, busy.
interface uart_char_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx;
  logic [DATA_WIDTH-1:0] char_out;
  logic                  enter;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output rx,
    input  char_out,
    input  enter,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output char_out,
    output enter,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_char_rx.sv
// 8N1 UART character receiver with programmable-width enter pulse.
// Ports: clk, reset_n (async low), bus (slave: rx in; char_out/enter/frame_err/busy out).
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int ENTER_CYCLES = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_char_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int EW = $clog2(ENTER_CYCLES + 1);

  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [EW-1:0] ELOAD = EW'(ENTER_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_m_q, rx_s_q, rx_d_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] char_q, char_d;
  logic [EW-1:0]         ecnt_q, ecnt_d;
  logic                  enter_q;
  logic                  ferr_q, ferr_d;
  logic                  expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      char_q  <= '0;
      ecnt_q  <= '0;
      enter_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m_q  <= bus.rx;
      rx_s_q  <= rx_m_q;
      rx_d_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      char_q  <= char_d;
      ecnt_q  <= ecnt_d;
      enter_q <= (ecnt_d != '0);
      ferr_q  <= ferr_d;
    end
  end

  assign expire = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = expire ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    char_d  = char_q;
    ferr_d  = 1'b0;
    ecnt_d  = (ecnt_q != '0) ? ecnt_q - 1'b1 : ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = FULL;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          // LSB-first: each new bit enters at the top
          sh_d = sh_q >> 1;
          sh_d[DATA_WIDTH-1] = rx_s_q;
          cnt_d = FULL;
          if (idx_q == LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (expire) begin
          state_d = IDLE;
          if (rx_s_q) begin
            char_d = sh_q;
            ecnt_d = ELOAD;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.char_out  = char_q;
  assign bus.enter     = enter_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_char_rx.sv
// Scoreboard bench for uart_char_rx: two instances (16/4 and 4/40 timing).
// Random and directed frames, glitches, framing errors and mid-frame reset.
module tb_uart_char_rx;

  localparam int W    = 8;
  localparam int CPB0 = 16;
  localparam int E0   = 4;
  localparam int CPB1 = 4;
  localparam int E1   = 40;

  typedef struct packed {
    logic         err;
    logic [W-1:0] ch;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];

  uart_char_rx_if #(.DATA_WIDTH(W)) if0 ();
  uart_char_rx_if #(.DATA_WIDTH(W)) if1 ();

  uart_char_rx #(
    .CLKS_PER_BIT(CPB0),
    .DATA_WIDTH  (W),
    .ENTER_CYCLES(E0)
  ) u_dut0 (
    .clk    (clk),
    .reset_n(rst_n[0]),
    .bus    (if0)
  );

  uart_char_rx #(
    .CLKS_PER_BIT(CPB1),
    .DATA_WIDTH  (W),
    .ENTER_CYCLES(E1)
  ) u_dut1 (
    .clk    (clk),
    .reset_n(rst_n[1]),
    .bus    (if1)
  );

  logic [W-1:0] chv [2];
  logic         env [2];
  logic         fev [2];
  logic         bsv [2];

  assign chv[0] = if0.char_out;
  assign chv[1] = if1.char_out;
  assign env[0] = if0.enter;
  assign env[1] = if1.enter;
  assign fev[0] = if0.frame_err;
  assign fev[1] = if1.frame_err;
  assign bsv[0] = if0.busy;
  assign bsv[1] = if1.busy;

  exp_t         sb [2][$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] model_last [2];
  int           since [2];
  logic         en_prev [2];
  bit           done = 1'b0;
  bit           fin_done = 1'b0;

  task automatic check(input string nm, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h",
               nm, d, act, exp);
    end
  endtask

  // Monitor: pops one expected item per observed character/error event.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        check("reset_char", d, chv[d], 0);
        check("reset_flags", d,
              {env[d], fev[d], bsv[d]}, 0);
        model_last[d] = '0;
        sb[d].delete();
        since[d] = 0;
        en_prev[d] = 1'b0;
      end else begin
        if (since[d] != 0) since[d]++;
        if (fev[d]) begin
          if (sb[d].size() == 0) begin
            check("unexpected_ferr", d, 1, 0);
          end else begin
            e = sb[d].pop_front();
            check("ferr_kind", d, 1, e.err);
          end
          check("char_hold_ferr", d, chv[d], model_last[d]);
          check("enter_on_ferr", d, env[d] && !en_prev[d], 0);
        end else if ((env[d] && !en_prev[d]) ||
                     (chv[d] != model_last[d])) begin
          if (sb[d].size() == 0) begin
            check("unexpected_char", d, 1, 0);
          end else begin
            e = sb[d].pop_front();
            check("char_kind", d, 0, e.err);
            check("char_out", d, chv[d], e.ch);
            check("enter_on_char", d, env[d], 1);
            check("busy_after_stop", d, bsv[d], 0);
            model_last[d] = e.ch;
          end
          since[d] = 1;
        end
        if (en_prev[d] && !env[d]) begin
          check("enter_width", d, since[d],
                (d == 0) ? E0 + 1 : E1 + 1);
          since[d] = 0;
        end
        en_prev[d] = env[d];
      end
    end
    if (done && !fin_done) begin
      fin_done = 1'b1;
      for (int d = 0; d < 2; d++)
        check("leftover_expected", d, sb[d].size(), 0);
    end
  end

  task automatic set_rx(input int d, input logic v);
    if (d == 0) if0.rx = v;
    else        if1.rx = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rst_at >= 0 pulses reset a quarter into that data bit.
  task automatic send_frame(input int d, input logic [W-1:0] ch,
                            input bit ok, input bit push,
                            input int rst_at);
    int cpb;
    cpb = (d == 0) ? CPB0 : CPB1;
    if (push) sb[d].push_back('{err: !ok, ch: ch});
    set_rx(d, 1'b0);
    wait_cyc(cpb);
    for (int i = 0; i < W; i++) begin
      set_rx(d, ch[i]);
      if (i == rst_at) begin
        wait_cyc(cpb / 4);
        @(posedge clk);
        #2 rst_n[d] = 1'b0;
        @(posedge clk);
        #2 rst_n[d] = 1'b1;
        @(negedge clk);
        wait_cyc(cpb - cpb / 4 - 2);
      end else begin
        wait_cyc(cpb);
      end
    end
    set_rx(d, ok);
    wait_cyc(cpb);
  endtask

  task automatic glitch(input int d, input int len);
    set_rx(d, 1'b0);
    wait_cyc(len);
    set_rx(d, 1'b1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int r;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    if0.rx = 1'b1;
    if1.rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    wait_cyc(20);

    send_frame(0, 8'h48, 1'b1, 1'b1, -1);
    wait_cyc(30);
    send_frame(0, 8'h48, 1'b1, 1'b1, -1);
    send_frame(0, 8'h41, 1'b1, 1'b1, -1);
    wait_cyc(30);
    send_frame(0, 8'h48, 1'b1, 1'b1, -1);
    wait_cyc(20);
    send_frame(0, 8'h55, 1'b0, 1'b1, -1);
    wait_cyc(40);
    set_rx(0, 1'b1);
    wait_cyc(40);
    glitch(0, 5);
    wait_cyc(40);
    send_frame(0, 8'hA5, 1'b1, 1'b0, 7);
    wait_cyc(40);
    send_frame(0, 8'h3C, 1'b1, 1'b1, -1);
    wait_cyc(30);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 99);
      a = W'($urandom);
      if (r < 60) begin
        send_frame(0, a, 1'b1, 1'b1, -1);
        wait_cyc($urandom_range(0, 20));
      end else if (r < 80) begin
        send_frame(0, a, 1'b0, 1'b1, -1);
        wait_cyc($urandom_range(0, 40));
        set_rx(0, 1'b1);
        wait_cyc(2 * CPB0);
      end else begin
        glitch(0, $urandom_range(1, 5));
        wait_cyc(2 * CPB0);
      end
    end

    send_frame(1, 8'h12, 1'b1, 1'b1, -1);
    send_frame(1, 8'h34, 1'b1, 1'b1, -1);
    wait_cyc(60);
    for (int n = 0; n < 6; n++) begin
      a = W'($urandom);
      b = a ^ W'($urandom_range(1, 255));
      send_frame(1, a, 1'b1, 1'b1, -1);
      send_frame(1, b, 1'b1, 1'b1, -1);
      wait_cyc($urandom_range(45, 60));
    end

    wait_cyc(20);
    done = 1'b1;
    wait_cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
